// File: rtl/fetch_queue.sv
// Instruction-fetch front end: sequential ROM fetch, PC-tagged instruction FIFO, redirect flush.
// Latency: request in cycle N, ROM data in N+1, head valid in N+2; 1 instr/cycle sustained.
// Backpressure: issue is credit-limited (count + inflight < DEPTH), so rom_req drops when decode stalls.
//
// Ports:
//   clk, rst                        clock, async active-high reset
//   redirect_valid_, redirect_addr_ flush queue and in-flight fetch, restart at word-aligned target
//   rom_req, rom_addr, rom_data     synchronous ROM, 1-cycle read latency
//   inst_valid, inst, inst_pc       queue head (NOP_INST / 0 when empty)
//   inst_ready                      decode accepts head
//   count                           occupied queue entries
module fetch_queue #(
    parameter int          DEPTH    = 4,
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter logic [31:0] NOP_INST = 32'h0000_0013
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       redirect_valid_,
    input  logic [31:0]                redirect_addr_,
    output logic                       rom_req,
    output logic [31:0]                rom_addr,
    input  logic [31:0]                rom_data,
    output logic                       inst_valid,
    output logic [31:0]                inst,
    output logic [31:0]                inst_pc,
    input  logic                       inst_ready,
    output logic [$clog2(DEPTH):0]     count
);

    localparam int AW = $clog2(DEPTH);
    localparam int PW = AW + 1;

    logic [31:0]   r_fetch_pc;
    logic          r_inflight;
    logic [31:0]   r_inflight_pc;
    logic [PW-1:0] r_rd_ptr;
    logic [PW-1:0] r_wr_ptr;
    logic [31:0]   r_q_inst [DEPTH];
    logic [31:0]   r_q_pc   [DEPTH];

    logic [PW-1:0] w_count;
    logic [PW:0]   w_credit;
    logic          w_empty;
    logic          w_full;
    logic          w_issue;
    logic          w_write;
    logic          w_pop;
    logic [AW-1:0] w_rd_idx;
    logic [AW-1:0] w_wr_idx;
    logic [31:0]   w_target;

    assign w_rd_idx = r_rd_ptr[AW-1:0];
    assign w_wr_idx = r_wr_ptr[AW-1:0];
    assign w_count  = r_wr_ptr - r_rd_ptr;
    assign w_empty  = (r_rd_ptr == r_wr_ptr);
    assign w_full   = (w_rd_idx == w_wr_idx) && (r_rd_ptr[AW] != r_wr_ptr[AW]);

    // Entries already queued plus the one response still coming back from the ROM;
    // reserving a slot for the in-flight word is what makes the return write never overflow.
    assign w_credit = {1'b0, w_count} + {{PW{1'b0}}, r_inflight};

    assign w_issue  = !rst && !redirect_valid_ && (w_credit < (PW+1)'(DEPTH));
    assign w_write  = r_inflight && !redirect_valid_;
    assign w_pop    = !w_empty && inst_ready && !redirect_valid_;
    assign w_target = redirect_addr_ & ~32'h0000_0003;

    assign rom_req    = w_issue;
    assign rom_addr   = r_fetch_pc;
    assign count      = w_count;
    assign inst_valid = !w_empty;
    assign inst       = w_empty ? NOP_INST : r_q_inst[w_rd_idx];
    assign inst_pc    = w_empty ? 32'h0000_0000 : r_q_pc[w_rd_idx];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_fetch_pc    <= {RESET_PC[31:2], 2'b00};
            r_inflight    <= 1'b0;
            r_inflight_pc <= 32'h0000_0000;
            r_rd_ptr      <= '0;
            r_wr_ptr      <= '0;
        end else if (redirect_valid_) begin
            // Drop everything queued and the response that would land next cycle.
            r_fetch_pc <= w_target;
            r_inflight <= 1'b0;
            r_rd_ptr   <= '0;
            r_wr_ptr   <= '0;
        end else begin
            r_inflight <= w_issue;
            if (w_issue) begin
                r_fetch_pc    <= r_fetch_pc + 32'd4;
                r_inflight_pc <= r_fetch_pc;
            end
            if (w_write) begin
                r_wr_ptr <= r_wr_ptr + PW'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + PW'(1);
            end
        end
    end

    // Storage needs no reset: pointers alone define which entries are live.
    always_ff @(posedge clk) begin
        if (w_write) begin
            r_q_inst[w_wr_idx] <= rom_data;
            r_q_pc[w_wr_idx]   <= r_inflight_pc;
        end
    end

    a_no_overflow: assert property (@(posedge clk) disable iff (rst) !(w_write && w_full));

endmodule

// File: tb/tb_fetch_queue.sv
// Self-checking bench for fetch_queue: expected PC stream held in a scoreboard queue,
// reloaded at each reset/redirect and popped on every accepted head.
module tb_fetch_queue;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        redirect_valid_ = 1'b0;
    logic [31:0] redirect_addr_ = 32'h0;
    logic        rom_req;
    logic [31:0] rom_addr;
    logic [31:0] rom_data = 32'h0;
    logic        inst_valid;
    logic [31:0] inst;
    logic [31:0] inst_pc;
    logic        inst_ready = 1'b1;
    logic [2:0]  count;

    int n_checks = 0;
    int n_pass   = 0;
    logic [31:0] sb_q[$];

    fetch_queue #(.DEPTH(4), .RESET_PC(32'h0), .NOP_INST(32'h13)) dut (
        .clk            (clk),
        .rst            (rst),
        .redirect_valid_(redirect_valid_),
        .redirect_addr_ (redirect_addr_),
        .rom_req        (rom_req),
        .rom_addr       (rom_addr),
        .rom_data       (rom_data),
        .inst_valid     (inst_valid),
        .inst           (inst),
        .inst_pc        (inst_pc),
        .inst_ready     (inst_ready),
        .count          (count)
    );

    always #5 clk = ~clk;

    // ROM word i holds 0x1000 + i.
    function automatic logic [31:0] rom_val(input logic [31:0] a);
        return 32'h1000 + (a >> 2);
    endfunction

    always @(posedge clk) rom_data <= rom_val(rom_addr);

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", tag, got, exp);
    endtask

    task automatic sb_load(input logic [31:0] start);
        sb_q.delete();
        for (int i = 0; i < 40; i++) sb_q.push_back(start + 32'(i * 4));
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic at_neg();
        @(negedge clk);
    endtask

    // Every accepted head must be the next expected PC with its ROM word.
    always @(negedge clk) begin
        if (!rst && !redirect_valid_ && inst_valid && inst_ready) begin
            if (sb_q.size() == 0) begin
                chk("sb_underflow", 32'(sb_q.size()), 32'd1);
            end else begin
                logic [31:0] e;
                e = sb_q.pop_front();
                chk("pop_pc", inst_pc, e);
                chk("pop_inst", inst, rom_val(e));
            end
        end
    end

    initial begin
        // Reset state
        step(2);
        at_neg();
        chk("rst_req", 32'(rom_req), 32'd0);
        chk("rst_vld", 32'(inst_valid), 32'd0);
        chk("rst_inst", inst, 32'h13);
        chk("rst_pc", inst_pc, 32'h0);
        chk("rst_cnt", 32'(count), 32'd0);

        // Release: fetch 0,4,8...; head valid in 3rd cycle
        step(1);
        rst = 1'b0;
        sb_load(32'h0);
        at_neg();
        chk("c1_req", 32'(rom_req), 32'd1);
        chk("c1_addr", rom_addr, 32'h0);
        chk("c1_vld", 32'(inst_valid), 32'd0);
        step(1);
        at_neg();
        chk("c2_addr", rom_addr, 32'h4);
        chk("c2_vld", 32'(inst_valid), 32'd0);
        step(1);
        at_neg();
        chk("c3_vld", 32'(inst_valid), 32'd1);
        chk("c3_inst", inst, 32'h1000);
        chk("c3_pc", inst_pc, 32'h0);
        for (int i = 0; i < 5; i++) begin
            step(1);
            at_neg();
            chk("thru_vld", 32'(inst_valid), 32'd1);
        end

        // Stall: queue fills, issue stops; resume in order
        step(1);
        inst_ready = 1'b0;
        step(10);
        at_neg();
        chk("stall_cnt", 32'(count), 32'd4);
        chk("stall_req", 32'(rom_req), 32'd0);
        chk("stall_vld", 32'(inst_valid), 32'd1);
        step(1);
        inst_ready = 1'b1;
        step(8);

        // Redirect with 3 queued + 1 in flight
        inst_ready = 1'b0;
        redirect_valid_ = 1'b1;
        redirect_addr_ = 32'h200;
        sb_load(32'h200);
        step(1);
        redirect_valid_ = 1'b0;
        step(4);
        chk("pre_cnt", 32'(count), 32'd3);
        chk("pre_req", 32'(rom_req), 32'd0);
        redirect_valid_ = 1'b1;
        redirect_addr_ = 32'h102;
        sb_load(32'h100);
        step(1);
        redirect_valid_ = 1'b0;
        inst_ready = 1'b1;
        at_neg();
        chk("rd_vld", 32'(inst_valid), 32'd0);
        chk("rd_cnt", 32'(count), 32'd0);
        chk("rd_addr", rom_addr, 32'h100);
        chk("rd_req", 32'(rom_req), 32'd1);
        step(8);

        // Redirect in the same cycle as a would-be pop
        at_neg();
        chk("pre2_vld", 32'(inst_valid), 32'd1);
        step(1);
        redirect_valid_ = 1'b1;
        redirect_addr_ = 32'h300;
        sb_load(32'h300);
        step(1);
        redirect_valid_ = 1'b0;
        at_neg();
        chk("rp_vld", 32'(inst_valid), 32'd0);
        chk("rp_cnt", 32'(count), 32'd0);
        chk("rp_addr", rom_addr, 32'h300);
        step(6);

        // Back-to-back redirects: last wins
        redirect_valid_ = 1'b1;
        redirect_addr_ = 32'h400;
        sb_load(32'h400);
        step(1);
        redirect_addr_ = 32'h504;
        sb_load(32'h504);
        step(1);
        redirect_valid_ = 1'b0;
        at_neg();
        chk("b2b_addr", rom_addr, 32'h504);
        step(6);

        // Address wrap, with unaligned target bits dropped
        redirect_valid_ = 1'b1;
        redirect_addr_ = 32'hFFFF_FFFB;
        sb_load(32'hFFFF_FFF8);
        step(1);
        redirect_valid_ = 1'b0;
        at_neg();
        chk("wr_addr0", rom_addr, 32'hFFFF_FFF8);
        step(1);
        at_neg();
        chk("wr_addr1", rom_addr, 32'hFFFF_FFFC);
        step(1);
        at_neg();
        chk("wr_addr2", rom_addr, 32'h0);
        step(6);

        // Async reset mid-cycle with the queue full
        inst_ready = 1'b0;
        step(10);
        at_neg();
        chk("full_cnt", 32'(count), 32'd4);
        step(1);
        #2;
        rst = 1'b1;
        sb_q.delete();
        #1;
        chk("ar_vld", 32'(inst_valid), 32'd0);
        chk("ar_inst", inst, 32'h13);
        chk("ar_pc", inst_pc, 32'h0);
        chk("ar_cnt", 32'(count), 32'd0);
        chk("ar_req", 32'(rom_req), 32'd0);
        step(2);
        rst = 1'b0;
        inst_ready = 1'b1;
        sb_load(32'h0);
        at_neg();
        chk("rr_addr", rom_addr, 32'h0);
        chk("rr_req", 32'(rom_req), 32'd1);
        step(8);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
